// File: rtl/waddr_fwd_pipe_pkg.sv
// Shared definitions for the MEM/WB write-address pipe of the 8-bit MIPS core.
// Provides the default address/data widths, the operand forward-select encodings
// and the index of the hardwired-zero register.
package waddr_fwd_pipe_pkg;

  localparam int unsigned AwDefault = 3;
  localparam int unsigned DwDefault = 8;

  // r0 reads as zero, so a write to it is never a real write or a forward source.
  localparam int unsigned ZeroReg = 0;

  typedef enum logic [1:0] {
    FwdRf  = 2'b00,
    FwdMem = 2'b01,
    FwdWb  = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/waddr_fwd_pipe_fwd_sel.sv
// Operand forward-select for one ALU source.
// Ports:
//   src        source register address of the EX instruction
//   m_writing  MEM slot is valid, writes, and targets a non-zero register
//   m_memread  MEM slot holds a load (its data is not available yet)
//   m_waddr    MEM slot destination
//   w_writing  WB slot is valid, writes, and targets a non-zero register
//   w_waddr    WB slot destination
//   sel        00 regfile, 01 MEM slot, 10 WB slot
module waddr_fwd_pipe_fwd_sel
  import waddr_fwd_pipe_pkg::*;
#(
  parameter int unsigned AW = AwDefault
) (
  input  logic [AW-1:0] src,
  input  logic          m_writing,
  input  logic          m_memread,
  input  logic [AW-1:0] m_waddr,
  input  logic          w_writing,
  input  logic [AW-1:0] w_waddr,
  output logic [1:0]    sel
);

  fwd_sel_e sel_e;

  // MEM is checked first so the youngest producer wins when both match.
  always_comb begin
    sel_e = FwdRf;
    if (m_writing && !m_memread && (m_waddr == src)) begin
      sel_e = FwdMem;
    end else if (w_writing && (w_waddr == src)) begin
      sel_e = FwdWb;
    end
  end

  assign sel = sel_e;

endmodule

// File: rtl/waddr_fwd_pipe.sv
// MEM/WB pipeline slots for the destination register of the EX instruction.
// Carries address, result and write controls through MEM and WB, drives the
// register-file write port from WB, and generates ALU forward selects and the
// load-use stall request.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   ex_*                       EX instruction (valid, dest, controls, result, sources)
//   id_rs, id_rt, id_rt_used   ID instruction sources for load-use detection
//   mem_rdata                  data memory read data for the MEM-slot load
//   flush                      squash the instruction entering MEM
//   fwd_a, fwd_b               operand selects for ex_rs / ex_rt
//   mem_fwd_data               MEM-slot ALU result for forwarding
//   load_use_stall             one-cycle ID/IF stall request
//   wb_we, wb_waddr, wb_wdata  register-file write port
module waddr_fwd_pipe
  import waddr_fwd_pipe_pkg::*;
#(
  parameter int unsigned AW = AwDefault,
  parameter int unsigned DW = DwDefault
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  input  logic [AW-1:0] ex_waddr,
  input  logic          ex_regwrite,
  input  logic          ex_memread,
  input  logic [DW-1:0] ex_result,
  input  logic [AW-1:0] ex_rs,
  input  logic [AW-1:0] ex_rt,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_rt_used,
  input  logic [DW-1:0] mem_rdata,
  input  logic          flush,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic [DW-1:0] mem_fwd_data,
  output logic          load_use_stall,
  output logic          wb_we,
  output logic [AW-1:0] wb_waddr,
  output logic [DW-1:0] wb_wdata
);

  localparam logic [AW-1:0] ZeroAddr = AW'(ZeroReg);

  logic          m_valid_q, m_regwrite_q, m_memread_q;
  logic [AW-1:0] m_waddr_q;
  logic [DW-1:0] m_result_q;

  logic          w_valid_q, w_regwrite_q;
  logic [AW-1:0] w_waddr_q;
  logic [DW-1:0] w_data_q;

  logic m_writing, w_writing;

  // The slots never hold: on a stall, upstream inserts a bubble via ex_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q    <= 1'b0;
      m_regwrite_q <= 1'b0;
      m_memread_q  <= 1'b0;
      m_waddr_q    <= '0;
      m_result_q   <= '0;
      w_valid_q    <= 1'b0;
      w_regwrite_q <= 1'b0;
      w_waddr_q    <= '0;
      w_data_q     <= '0;
    end else begin
      m_valid_q    <= ex_valid & ~flush;
      m_regwrite_q <= ex_regwrite;
      m_memread_q  <= ex_memread;
      m_waddr_q    <= ex_waddr;
      m_result_q   <= ex_result;
      w_valid_q    <= m_valid_q;
      w_regwrite_q <= m_regwrite_q;
      w_waddr_q    <= m_waddr_q;
      w_data_q     <= m_memread_q ? mem_rdata : m_result_q;
    end
  end

  assign m_writing = m_valid_q & m_regwrite_q & (m_waddr_q != ZeroAddr);
  assign w_writing = w_valid_q & w_regwrite_q & (w_waddr_q != ZeroAddr);

  assign wb_we        = w_writing;
  assign wb_waddr     = w_waddr_q;
  assign wb_wdata     = w_data_q;
  assign mem_fwd_data = m_result_q;

  assign load_use_stall = ex_valid & ex_memread & ex_regwrite & (ex_waddr != ZeroAddr) &
                          ((ex_waddr == id_rs) | (id_rt_used & (ex_waddr == id_rt)));

  waddr_fwd_pipe_fwd_sel #(
    .AW(AW)
  ) u_fwd_sel_a (
    .src      (ex_rs),
    .m_writing(m_writing),
    .m_memread(m_memread_q),
    .m_waddr  (m_waddr_q),
    .w_writing(w_writing),
    .w_waddr  (w_waddr_q),
    .sel      (fwd_a)
  );

  waddr_fwd_pipe_fwd_sel #(
    .AW(AW)
  ) u_fwd_sel_b (
    .src      (ex_rt),
    .m_writing(m_writing),
    .m_memread(m_memread_q),
    .m_waddr  (m_waddr_q),
    .w_writing(w_writing),
    .w_waddr  (w_waddr_q),
    .sel      (fwd_b)
  );

endmodule

// File: tb/tb_waddr_fwd_pipe.sv
module tb_waddr_fwd_pipe;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_valid, ex_regwrite, ex_memread, flush, id_rt_used;
  logic [AW-1:0] ex_waddr, ex_rs, ex_rt, id_rs, id_rt;
  logic [DW-1:0] ex_result, mem_rdata;
  logic [1:0]    fwd_a, fwd_b;
  logic [DW-1:0] mem_fwd_data;
  logic          load_use_stall, wb_we;
  logic [AW-1:0] wb_waddr;
  logic [DW-1:0] wb_wdata;

  typedef struct {
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
  } wb_exp_t;

  wb_exp_t q[$];
  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  waddr_fwd_pipe #(
    .AW(AW),
    .DW(DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_waddr      (ex_waddr),
    .ex_regwrite   (ex_regwrite),
    .ex_memread    (ex_memread),
    .ex_result     (ex_result),
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rt_used    (id_rt_used),
    .mem_rdata     (mem_rdata),
    .flush         (flush),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
    .mem_fwd_data  (mem_fwd_data),
    .load_use_stall(load_use_stall),
    .wb_we         (wb_we),
    .wb_waddr      (wb_waddr),
    .wb_wdata      (wb_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one EX instruction and record what WB must show two edges later.
  // mem_rdata stays constant outside reset, so a load's data is known here.
  task automatic drive(input logic v, input logic [AW-1:0] wa, input logic rw, input logic mr,
                       input logic [DW-1:0] res, input logic [AW-1:0] rs,
                       input logic [AW-1:0] rt, input logic fl);
    wb_exp_t e;
    ex_valid    = v;
    ex_waddr    = wa;
    ex_regwrite = rw;
    ex_memread  = mr;
    ex_result   = res;
    ex_rs       = rs;
    ex_rt       = rt;
    flush       = fl;
    e.we    = v & ~fl & rw & (wa != 0);
    e.waddr = wa;
    e.wdata = mr ? mem_rdata : res;
    q.push_back(e);
    #1;
  endtask

  // Advance one edge and compare the WB port against the oldest expectation.
  task automatic tick(input string tag);
    wb_exp_t e;
    @(posedge clk);
    #1;
    if (q.size() >= 2) begin
      e = q.pop_front();
      chk({tag, ".wb_we"}, 32'(wb_we), 32'(e.we));
      if (e.we) begin
        chk({tag, ".wb_waddr"}, 32'(wb_waddr), 32'(e.waddr));
        chk({tag, ".wb_wdata"}, 32'(wb_wdata), 32'(e.wdata));
      end
    end
  endtask

  initial begin
    // Reset with random data inputs; ex_valid must be low during reset.
    rst        = 1'b1;
    ex_valid   = 1'b0;
    id_rt_used = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ex_waddr    = AW'($urandom);
      ex_regwrite = 1'($urandom);
      ex_memread  = 1'($urandom);
      ex_result   = DW'($urandom);
      ex_rs       = AW'($urandom);
      ex_rt       = AW'($urandom);
      id_rs       = AW'($urandom);
      id_rt       = AW'($urandom);
      mem_rdata   = DW'($urandom);
      flush       = 1'($urandom);
      @(posedge clk);
      #1;
    end
    rst       = 1'b0;
    mem_rdata = 8'h3C;
    id_rs     = '0;
    id_rt     = '0;
    ex_valid  = 1'b0;
    flush     = 1'b0;
    #1;
    chk("rst.wb_we", 32'(wb_we), 32'd0);
    chk("rst.wb_waddr", 32'(wb_waddr), 32'd0);
    chk("rst.wb_wdata", 32'(wb_wdata), 32'd0);
    chk("rst.fwd_a", 32'(fwd_a), 32'd0);
    chk("rst.fwd_b", 32'(fwd_b), 32'd0);
    chk("rst.mem_fwd", 32'(mem_fwd_data), 32'd0);
    chk("rst.stall", 32'(load_use_stall), 32'd0);
    q.push_back('{we: 1'b0, waddr: '0, wdata: '0});

    // r3 = 0x5A, then consumers in MEM and WB distance.
    drive(1, 3, 1, 0, 8'h5A, 0, 0, 0);
    tick("s1");
    drive(1, 1, 1, 0, 8'h10, 3, 0, 0);
    chk("b2b.fwd_a", 32'(fwd_a), 32'h1);
    chk("b2b.mem_fwd", 32'(mem_fwd_data), 32'h5A);
    chk("b2b.fwd_b", 32'(fwd_b), 32'h0);
    tick("s2");
    drive(1, 2, 1, 0, 8'h11, 0, 3, 0);
    chk("b2b.fwd_b_wb", 32'(fwd_b), 32'h2);
    chk("b2b.fwd_a_none", 32'(fwd_a), 32'h0);
    tick("s3");

    // r2 = 0x11 in WB, r2 = 0x22 in MEM: MEM wins.
    drive(1, 2, 1, 0, 8'h22, 0, 0, 0);
    tick("s4");
    drive(1, 0, 1, 0, 8'hFF, 2, 2, 0);
    chk("prio.fwd_a", 32'(fwd_a), 32'h1);
    chk("prio.fwd_b", 32'(fwd_b), 32'h1);
    chk("prio.mem_fwd", 32'(mem_fwd_data), 32'h22);
    tick("s5");

    // MEM holds a write to r0 (never forwards); WB holds r2 = 0x22.
    drive(1, 1, 0, 0, 8'h33, 0, 2, 0);
    chk("zero.fwd_a", 32'(fwd_a), 32'h0);
    chk("zero.fwd_b_wb", 32'(fwd_b), 32'h2);
    tick("s6");

    // Load to r4 with the ID instruction reading rt = r4.
    id_rt      = 4;
    id_rt_used = 1'b1;
    drive(1, 4, 1, 1, 8'h80, 1, 0, 0);
    chk("lu.stall_rt", 32'(load_use_stall), 32'h1);
    chk("lu.fwd_a_noreg", 32'(fwd_a), 32'h0);
    id_rt_used = 1'b0;
    id_rs      = 2;
    #1;
    chk("lu.no_stall", 32'(load_use_stall), 32'h0);
    id_rs = 4;
    #1;
    chk("lu.stall_rs", 32'(load_use_stall), 32'h1);
    tick("s7");

    // Bubble: the load in MEM is not a forward source.
    drive(0, 4, 1, 1, 8'h00, 4, 4, 0);
    chk("lu.bubble_stall", 32'(load_use_stall), 32'h0);
    chk("lu.fwd_a_load", 32'(fwd_a), 32'h0);
    id_rs = 0;
    id_rt = 0;
    tick("s8");
    drive(1, 6, 1, 0, 8'h66, 4, 0, 0);
    chk("lu.fwd_a_wb", 32'(fwd_a), 32'h2);
    tick("s9");

    // Flushed write to r5 neither forwards nor writes.
    drive(1, 5, 1, 0, 8'h55, 0, 0, 1);
    tick("s10");
    drive(1, 1, 1, 0, 8'h01, 5, 6, 0);
    chk("flush.fwd_a", 32'(fwd_a), 32'h0);
    chk("flush.fwd_b_wb", 32'(fwd_b), 32'h2);
    tick("s11");
    drive(0, 0, 0, 0, 8'h00, 0, 0, 0);
    tick("s12");
    drive(0, 0, 0, 0, 8'h00, 0, 0, 0);
    tick("s13");

    // Reset mid-stream, with flush also high: both slots empty, no write issued.
    drive(1, 7, 1, 0, 8'h77, 0, 0, 0);
    tick("s14");
    rst = 1'b1;
    drive(1, 3, 1, 0, 8'h99, 0, 0, 1);
    @(posedge clk);
    #1;
    q.delete();
    rst = 1'b0;
    drive(0, 0, 0, 0, 8'h00, 7, 3, 0);
    q.delete();
    chk("mrst.wb_we", 32'(wb_we), 32'h0);
    chk("mrst.wb_wdata", 32'(wb_wdata), 32'h0);
    chk("mrst.mem_fwd", 32'(mem_fwd_data), 32'h0);
    chk("mrst.fwd_a", 32'(fwd_a), 32'h0);
    chk("mrst.fwd_b", 32'(fwd_b), 32'h0);
    @(posedge clk);
    #1;
    chk("mrst.wb_we_after", 32'(wb_we), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
